pipeline_controller: RTL and testbench

- Hazard, stall and flush sequencer for the five-stage core pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-register enables and flushes, PC update control and EX-stage operand forwarding selects.
- Sequences multi-cycle instruction-memory and data-memory handshakes, plus a data-memory timeout watchdog and a stall-cycle counter.
- Sits beside the dataflow. It is driven by decoded register indices from each pipeline register and by memory request/ack signals.

---
 rtl/pipeline_controller.sv | 219 +++++++++++++++++++++
 tb/tb_pipeline_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Hazard, stall and flush sequencer for a five-stage pipeline: register enables/flushes,
// PC update control, EX operand forwarding, memory handshakes, dmem watchdog and stall counter.
module pipeline_controller #(
    parameter int unsigned DataSize    = 64,
    parameter int unsigned DmemTimeout = 255
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [4:0]          i_id_rs1,
    input  logic [4:0]          i_id_rs2,
    input  logic                i_id_uses_rs1,
    input  logic                i_id_uses_rs2,
    input  logic [4:0]          i_ex_rs1,
    input  logic [4:0]          i_ex_rs2,
    input  logic [4:0]          i_ex_rd,
    input  logic                i_ex_reg_we,
    input  logic                i_ex_mem_read,
    input  logic [4:0]          i_mem_rd,
    input  logic                i_mem_reg_we,
    input  logic [4:0]          i_wb_rd,
    input  logic                i_wb_reg_we,
    input  logic                i_branch_taken,
    input  logic                i_trap,
    output logic                o_imem_req,
    input  logic                i_imem_ack,
    input  logic                i_dmem_access,
    output logic                o_dmem_req,
    input  logic                i_dmem_ack,
    output logic                o_pc_en,
    output logic [1:0]          o_pc_src,
    output logic                o_if_id_en,
    output logic                o_id_ex_en,
    output logic                o_ex_mem_en,
    output logic                o_mem_wb_en,
    output logic                o_if_id_flush,
    output logic                o_id_ex_flush,
    output logic                o_ex_mem_flush,
    output logic                o_mem_wb_flush,
    output logic [1:0]          o_forward_a,
    output logic [1:0]          o_forward_b,
    output logic                o_dmem_timeout,
    output logic [DataSize-1:0] o_stall_count
);

    localparam int unsigned WdW = $clog2(DmemTimeout + 1);

    localparam logic [1:0] PcSeq    = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcTrap   = 2'b10;

    typedef enum logic [1:0] {StRun, StImemWait, StDmemWait, StTrapFlush} state_e;

    state_e              r_state, w_state_next;
    logic [WdW-1:0]      r_wdog, w_wdog_next, w_wdog_inc;
    logic [DataSize-1:0] r_stall_count;
    logic                w_load_use;

    // The load-use check keys on ex_mem_read alone; ex_reg_we is not needed here.
    logic w_unused;
    assign w_unused = i_ex_reg_we;

    // EX/MEM beats MEM/WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (i_mem_reg_we && (i_mem_rd != 5'd0) && (i_mem_rd == rs)) return 2'b10;
        if (i_wb_reg_we && (i_wb_rd != 5'd0) && (i_wb_rd == rs))    return 2'b01;
        return 2'b00;
    endfunction

    assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                        ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

    assign w_wdog_inc = r_wdog + 1'b1;

    // Next-state and all control outputs; reset forces the idle/bubble values asynchronously.
    always_comb begin
        w_state_next   = r_state;
        w_wdog_next    = r_wdog;
        o_imem_req     = 1'b0;
        o_dmem_req     = 1'b0;
        o_pc_en        = 1'b1;
        o_pc_src       = PcSeq;
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        o_mem_wb_flush = 1'b0;
        o_dmem_timeout = 1'b0;
        o_forward_a    = fwd_sel(i_ex_rs1);
        o_forward_b    = fwd_sel(i_ex_rs2);

        unique case (r_state)
            StRun: begin
                o_imem_req = 1'b1;
                if (i_trap) begin
                    // Hold PC for the vector load next cycle; kill the trapping
                    // instruction and anything younger entering EX/MEM.
                    o_pc_en        = 1'b0;
                    o_pc_src       = PcTrap;
                    o_if_id_en     = 1'b0;
                    o_id_ex_en     = 1'b0;
                    o_ex_mem_flush = 1'b1;
                    o_mem_wb_flush = 1'b1;
                    w_state_next   = StTrapFlush;
                end else if (i_dmem_access && !i_dmem_ack) begin
                    // Freeze IF..EX/MEM; a coincident branch stays in ID/EX and re-asserts.
                    o_dmem_req     = 1'b1;
                    o_pc_en        = 1'b0;
                    o_if_id_en     = 1'b0;
                    o_id_ex_en     = 1'b0;
                    o_ex_mem_en    = 1'b0;
                    o_mem_wb_flush = 1'b1;
                    w_state_next   = StDmemWait;
                end else begin
                    o_dmem_req = i_dmem_access;
                    if (i_branch_taken) begin
                        // Branch flushes IF/ID, so a load-use hazard there is moot.
                        o_pc_src      = PcBranch;
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end else if (w_load_use) begin
                        o_pc_en       = 1'b0;
                        o_if_id_en    = 1'b0;
                        o_id_ex_flush = 1'b1;
                    end else if (!i_imem_ack) begin
                        o_pc_en       = 1'b0;
                        o_if_id_flush = 1'b1;
                        w_state_next  = StImemWait;
                    end
                end
            end
            StImemWait: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    w_state_next = StRun;
                end else begin
                    o_pc_en       = 1'b0;
                    o_if_id_flush = 1'b1;
                end
            end
            StDmemWait: begin
                o_dmem_req  = 1'b1;
                o_pc_en     = 1'b0;
                o_if_id_en  = 1'b0;
                o_id_ex_en  = 1'b0;
                o_ex_mem_en = 1'b0;
                if (i_dmem_ack) begin
                    w_wdog_next  = '0;
                    w_state_next = StRun;
                end else if (w_wdog_inc == WdW'(DmemTimeout)) begin
                    o_mem_wb_flush = 1'b1;
                    o_dmem_timeout = 1'b1;
                    w_wdog_next    = '0;
                    w_state_next   = StTrapFlush;
                end else begin
                    o_mem_wb_flush = 1'b1;
                    w_wdog_next    = w_wdog_inc;
                end
            end
            StTrapFlush: begin
                // MEM/WB is also flushed: after a timeout EX/MEM still holds the dead access.
                o_pc_en        = 1'b1;
                o_pc_src       = PcTrap;
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
                o_mem_wb_flush = 1'b1;
                w_state_next   = StRun;
            end
            default: w_state_next = StRun;
        endcase

        if (!i_reset_n) begin
            w_state_next   = StRun;
            w_wdog_next    = '0;
            o_imem_req     = 1'b0;
            o_dmem_req     = 1'b0;
            o_pc_en        = 1'b0;
            o_pc_src       = PcSeq;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_en    = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
            o_mem_wb_flush = 1'b1;
            o_dmem_timeout = 1'b0;
            o_forward_a    = 2'b00;
            o_forward_b    = 2'b00;
        end
    end

    // State and watchdog registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StRun;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wdog  <= w_wdog_next;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_count <= '0;
        end else if (!o_pc_en && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed, table-driven bench for pipeline_controller plus multi-cycle sequences.
module tb_pipeline_controller;

    localparam int unsigned DataSize    = 4;
    localparam int unsigned DmemTimeout = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_u1, id_u2, ex_we, ex_mr, mem_we, wb_we, br, trap, imem_ack, dacc, dack;
    logic imem_req, dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, dmem_timeout;
    logic [1:0] pc_src, fa, fb;
    logic [DataSize-1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_controller #(.DataSize(DataSize), .DmemTimeout(DmemTimeout)) dut (
        .i_clock(clk), .i_reset_n(reset_n),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_uses_rs1(id_u1), .i_id_uses_rs2(id_u2),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd), .i_ex_reg_we(ex_we),
        .i_ex_mem_read(ex_mr), .i_mem_rd(mem_rd), .i_mem_reg_we(mem_we), .i_wb_rd(wb_rd),
        .i_wb_reg_we(wb_we), .i_branch_taken(br), .i_trap(trap), .o_imem_req(imem_req),
        .i_imem_ack(imem_ack), .i_dmem_access(dacc), .o_dmem_req(dmem_req), .i_dmem_ack(dack),
        .o_pc_en(pc_en), .o_pc_src(pc_src), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en),
        .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en), .o_if_id_flush(if_id_flush),
        .o_id_ex_flush(id_ex_flush), .o_ex_mem_flush(ex_mem_flush),
        .o_mem_wb_flush(mem_wb_flush), .o_forward_a(fa), .o_forward_b(fb),
        .o_dmem_timeout(dmem_timeout), .o_stall_count(stall_count)
    );

    typedef struct {
        logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
        logic       id_u1, id_u2, ex_we, ex_mr, mem_we, wb_we, br, dacc, dack;
        logic       e_pc_en, e_if_id_en, e_if_id_flush, e_id_ex_flush, e_dreq;
        logic [1:0] e_pc_src, e_fa, e_fb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Quiet RUN-state stimulus with expected normal-flow outputs.
    function automatic vec_t base();
        vec_t v;
        v.id_rs1 = 0; v.id_rs2 = 0; v.ex_rs1 = 0; v.ex_rs2 = 0; v.ex_rd = 0;
        v.mem_rd = 0; v.wb_rd = 0; v.id_u1 = 0; v.id_u2 = 0; v.ex_we = 0; v.ex_mr = 0;
        v.mem_we = 0; v.wb_we = 0; v.br = 0; v.dacc = 0; v.dack = 0;
        v.e_pc_en = 1; v.e_if_id_en = 1; v.e_if_id_flush = 0; v.e_id_ex_flush = 0;
        v.e_dreq = 0; v.e_pc_src = 2'b00; v.e_fa = 2'b00; v.e_fb = 2'b00;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
        ex_rd = v.ex_rd; mem_rd = v.mem_rd; wb_rd = v.wb_rd; id_u1 = v.id_u1; id_u2 = v.id_u2;
        ex_we = v.ex_we; ex_mr = v.ex_mr; mem_we = v.mem_we; wb_we = v.wb_we; br = v.br;
        dacc = v.dacc; dack = v.dack; trap = 0; imem_ack = 1;
    endtask

    task automatic quiet();
        apply(base());
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc_en"}, pc_en, 0);          chk({tag, ".pc_src"}, pc_src, 0);
        chk({tag, ".if_id_en"}, if_id_en, 0);    chk({tag, ".id_ex_en"}, id_ex_en, 0);
        chk({tag, ".ex_mem_en"}, ex_mem_en, 0);  chk({tag, ".mem_wb_en"}, mem_wb_en, 0);
        chk({tag, ".if_id_fl"}, if_id_flush, 1); chk({tag, ".id_ex_fl"}, id_ex_flush, 1);
        chk({tag, ".ex_mem_fl"}, ex_mem_flush, 1); chk({tag, ".mem_wb_fl"}, mem_wb_flush, 1);
        chk({tag, ".imem_req"}, imem_req, 0);    chk({tag, ".dmem_req"}, dmem_req, 0);
        chk({tag, ".fa"}, fa, 0);                chk({tag, ".fb"}, fb, 0);
        chk({tag, ".timeout"}, dmem_timeout, 0); chk({tag, ".stall"}, stall_count, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v;
        // Forwarding table.
        v = base(); v.mem_rd = 5; v.mem_we = 1; v.wb_rd = 5; v.wb_we = 1; v.ex_rs1 = 5;
        v.e_fa = 2'b10; vecs.push_back(v);
        v.mem_we = 0; v.e_fa = 2'b01; vecs.push_back(v);
        v = base(); v.mem_we = 1; v.wb_we = 1; vecs.push_back(v);
        v = base(); v.ex_rs2 = 9; v.mem_rd = 9; v.mem_we = 1; v.ex_rs1 = 3; v.wb_rd = 3;
        v.wb_we = 1; v.e_fb = 2'b10; v.e_fa = 2'b01; vecs.push_back(v);
        v = base(); v.ex_rs2 = 12; v.wb_rd = 12; v.wb_we = 1; v.mem_rd = 12;
        v.e_fb = 2'b01; vecs.push_back(v);
        v = base(); v.mem_rd = 4; v.mem_we = 1; v.ex_rs1 = 5; vecs.push_back(v);
        // Load-use on rs2: one-cycle stall.
        v = base(); v.ex_mr = 1; v.ex_we = 1; v.ex_rd = 7; v.id_rs2 = 7; v.id_u2 = 1;
        v.e_pc_en = 0; v.e_if_id_en = 0; v.e_id_ex_flush = 1; vecs.push_back(v);
        // Matching rs1 that is not read: no hazard.
        v = base(); v.ex_mr = 1; v.ex_we = 1; v.ex_rd = 7; v.id_rs1 = 7; vecs.push_back(v);
        // Load to x0: no hazard.
        v = base(); v.ex_mr = 1; v.id_u1 = 1; vecs.push_back(v);
        // Not a load: no hazard.
        v = base(); v.ex_we = 1; v.ex_rd = 6; v.id_rs1 = 6; v.id_u1 = 1; vecs.push_back(v);
        // Branch.
        v = base(); v.br = 1; v.e_pc_src = 2'b01; v.e_if_id_flush = 1; v.e_id_ex_flush = 1;
        vecs.push_back(v);
        // Branch with load-use: hazard discarded.
        v.ex_mr = 1; v.ex_we = 1; v.ex_rd = 7; v.id_rs2 = 7; v.id_u2 = 1; vecs.push_back(v);
        // Zero-wait data access, then with a branch.
        v = base(); v.dacc = 1; v.dack = 1; v.e_dreq = 1; vecs.push_back(v);
        v.br = 1; v.e_pc_src = 2'b01; v.e_if_id_flush = 1; v.e_id_ex_flush = 1;
        vecs.push_back(v);

        // Reset values, with inputs that would otherwise forward.
        quiet();
        reset_n = 0;
        mem_rd = 5; mem_we = 1; ex_rs1 = 5; ex_rs2 = 5;
        smp();
        chk_reset("reset");
        cyc();
        reset_n = 1;
        quiet();
        smp();
        chk("post_reset.pc_en", pc_en, 1);
        chk("post_reset.imem_req", imem_req, 1);
        chk("post_reset.stall", stall_count, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc();
            apply(vecs[i]);
            smp();
            chk($sformatf("v%0d.pc_en", i), pc_en, vecs[i].e_pc_en);
            chk($sformatf("v%0d.pc_src", i), pc_src, vecs[i].e_pc_src);
            chk($sformatf("v%0d.if_id_en", i), if_id_en, vecs[i].e_if_id_en);
            chk($sformatf("v%0d.if_id_fl", i), if_id_flush, vecs[i].e_if_id_flush);
            chk($sformatf("v%0d.id_ex_fl", i), id_ex_flush, vecs[i].e_id_ex_flush);
            chk($sformatf("v%0d.fa", i), fa, vecs[i].e_fa);
            chk($sformatf("v%0d.fb", i), fb, vecs[i].e_fb);
            chk($sformatf("v%0d.dmem_req", i), dmem_req, vecs[i].e_dreq);
        end
        cyc(); quiet(); smp();
        chk("table.stall", stall_count, 1);

        // Data wait: ack on third stalled cycle; coincident branch is held.
        cyc(); dacc = 1; br = 1; smp();
        chk("dw0.pc_en", pc_en, 0); chk("dw0.dreq", dmem_req, 1);
        chk("dw0.pc_src", pc_src, 0); chk("dw0.mwb_fl", mem_wb_flush, 1);
        chk("dw0.exm_en", ex_mem_en, 0);
        cyc(); smp();
        chk("dw1.pc_en", pc_en, 0); chk("dw1.dreq", dmem_req, 1);
        cyc(); dack = 1; smp();
        chk("dw2.pc_en", pc_en, 0); chk("dw2.dreq", dmem_req, 1);
        chk("dw2.mwb_en", mem_wb_en, 1); chk("dw2.mwb_fl", mem_wb_flush, 0);
        cyc(); dacc = 0; dack = 0; smp();
        chk("dw3.pc_en", pc_en, 1); chk("dw3.pc_src", pc_src, 2'b01);
        chk("dw3.dreq", dmem_req, 0); chk("dw3.stall", stall_count, 4);

        // Watchdog timeout on the fourth DMEM_WAIT cycle.
        cyc(); quiet(); dacc = 1; smp();
        chk("to0.pc_en", pc_en, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(); smp();
            chk($sformatf("to%0d.timeout", k), dmem_timeout, (k == 4) ? 1 : 0);
            chk($sformatf("to%0d.dreq", k), dmem_req, 1);
        end
        cyc(); dacc = 0; smp();
        chk("tf.pc_en", pc_en, 1); chk("tf.pc_src", pc_src, 2'b10);
        chk("tf.if_id_fl", if_id_flush, 1); chk("tf.id_ex_fl", id_ex_flush, 1);
        chk("tf.ex_mem_fl", ex_mem_flush, 1); chk("tf.timeout", dmem_timeout, 0);
        chk("tf.stall", stall_count, 9);
        cyc(); smp();
        chk("tf_after.pc_src", pc_src, 0); chk("tf_after.pc_en", pc_en, 1);

        // Trap and branch together: trap wins.
        cyc(); trap = 1; br = 1; smp();
        chk("tb.pc_src", pc_src, 2'b10); chk("tb.mwb_fl", mem_wb_flush, 1);
        cyc(); trap = 0; br = 0; smp();
        chk("tb_tf.pc_src", pc_src, 2'b10); chk("tb_tf.pc_en", pc_en, 1);
        chk("tb_tf.ex_mem_fl", ex_mem_flush, 1);
        cyc(); smp();
        chk("tb_after.pc_src", pc_src, 0); chk("tb_after.stall", stall_count, 10);

        // Instruction fetch wait.
        cyc(); imem_ack = 0; smp();
        chk("iw0.pc_en", pc_en, 0); chk("iw0.if_id_fl", if_id_flush, 1);
        chk("iw0.imem_req", imem_req, 1); chk("iw0.id_ex_en", id_ex_en, 1);
        cyc(); smp();
        chk("iw1.pc_en", pc_en, 0); chk("iw1.imem_req", imem_req, 1);
        cyc(); imem_ack = 1; smp();
        chk("iw2.pc_en", pc_en, 1); chk("iw2.if_id_fl", if_id_flush, 0);
        cyc(); smp();
        chk("iw3.stall", stall_count, 12);

        // Stall counter saturation at all-ones.
        cyc(); imem_ack = 0;
        repeat (4) cyc();
        imem_ack = 1; smp();
        chk("sat0.stall", stall_count, 15);
        cyc(); smp();
        chk("sat1.stall", stall_count, 15);

        // Reset in the middle of a data wait.
        cyc(); dacc = 1; smp();
        cyc(); smp();
        chk("rw.dreq", dmem_req, 1);
        @(posedge clk); #3;
        reset_n = 0;
        #1;
        chk_reset("rst_mid");
        cyc();
        reset_n = 1;
        quiet();
        smp();
        chk("rel.pc_en", pc_en, 1); chk("rel.imem_req", imem_req, 1);
        chk("rel.dreq", dmem_req, 0); chk("rel.stall", stall_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
